// File: rtl/tt_pkg.sv
// Shared definitions for the truth-table sweeper: FSM state encoding and
// the minterm-count helper used to size the expected truth vector.
package tt_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_SAMPLE = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   // Number of minterms of an n-input function.
   function automatic int minterm_count(input int n);
      return 1 << n;
   endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Stimulus/response bundle between the sweeper (master) and the two
// implementations under exercise plus whoever requests sweeps (slave).
interface truth_table_sweeper_if #(
   parameter int N_IN = 2
);
   logic            start;
   logic [N_IN-1:0] x_out;
   logic            s_a;
   logic            s_b;
   logic            busy;
   logic            done;
   logic            mismatch;
   logic [N_IN:0]   err_count;
   logic [N_IN-1:0] first_err;

   modport master (
      input  start, s_a, s_b,
      output x_out, busy, done, mismatch, err_count, first_err
   );

   modport slave (
      output start, s_a, s_b,
      input  x_out, busy, done, mismatch, err_count, first_err
   );
endinterface

// File: rtl/tt_settle_timer.sv
// Down-counter that measures the settle window after each new minterm.
// Loads a value, counts down while enabled, and flags when it reaches zero.
module tt_settle_timer #(
   parameter int SETTLE = 1,
   parameter int CNT_W  = $clog2(SETTLE) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             dec,
   input  logic [CNT_W-1:0] value,
   output logic             zero
);

   logic [CNT_W-1:0] cnt;

   // Load on request, otherwise count down to zero and hold there.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= value;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: drives every minterm into two implementations of the
// same function, waits SETTLE cycles, compares their outputs and accumulates
// the mismatch count and the first failing minterm.
// Optional build macro TT_EXPECT_EN: additionally flags a minterm whose gate
// output differs from bit x_out of EXPECT, so two implementations that are
// wrong in the same way are still caught.
module truth_table_sweeper
   import tt_pkg::*;
#(
   parameter int                                N_IN   = 2,
   parameter int                                SETTLE = 1,
   parameter logic [minterm_count(N_IN)-1:0]    EXPECT = 'b0010
) (
   input  logic                  clk,
   input  logic                  rst_n,
   truth_table_sweeper_if.master bus
);

   localparam int              CNT_W  = $clog2(SETTLE) + 1;
   localparam logic [N_IN-1:0] LAST_X = N_IN'(minterm_count(N_IN) - 1);

   state_t           state;
   logic             err;
   logic             last_x;
   logic             tmr_load;
   logic             tmr_dec;
   logic             tmr_zero;
   logic [CNT_W-1:0] tmr_value;

   // Per-minterm error decision from the two implementation outputs.
   always_comb begin
`ifdef TT_EXPECT_EN
      err = (bus.s_a != bus.s_b) | (bus.s_a != EXPECT[bus.x_out]);
`else
      // EXPECT has no influence in this build; the masked term folds away.
      err = (bus.s_a != bus.s_b) | (1'b0 & EXPECT[bus.x_out]);
`endif
   end

   // Settle-timer control: reload on every fresh minterm, count during SETTLE.
   always_comb begin
      last_x    = (bus.x_out == LAST_X);
      tmr_load  = ((state == S_IDLE) && bus.start) ||
                  ((state == S_SAMPLE) && !last_x);
      tmr_dec   = (state == S_SETTLE);
      tmr_value = CNT_W'(SETTLE - 1);
   end

   tt_settle_timer #(
      .SETTLE (SETTLE),
      .CNT_W  (CNT_W)
   ) u_settle_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (tmr_load),
      .dec   (tmr_dec),
      .value (tmr_value),
      .zero  (tmr_zero)
   );

   // Sweep FSM with minterm counter and error accumulator; all outputs registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         bus.x_out     <= '0;
         bus.busy      <= 1'b0;
         bus.done      <= 1'b0;
         bus.mismatch  <= 1'b0;
         bus.err_count <= '0;
         bus.first_err <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  bus.x_out     <= '0;
                  bus.err_count <= '0;
                  bus.first_err <= '0;
                  bus.mismatch  <= 1'b0;
                  bus.busy      <= 1'b1;
                  state         <= S_SETTLE;
               end
            end
            S_SETTLE: begin
               if (tmr_zero) begin
                  state <= S_SAMPLE;
               end
            end
            S_SAMPLE: begin
               bus.mismatch <= err;
               if (err) begin
                  // Cannot wrap: at most 2^N_IN errors in an N_IN+1 bit counter.
                  bus.err_count <= bus.err_count + (N_IN+1)'(1);
                  if (bus.err_count == '0) begin
                     bus.first_err <= bus.x_out;
                  end
               end
               if (last_x) begin
                  bus.done <= 1'b1;
                  state    <= S_DONE;
               end else begin
                  bus.x_out <= bus.x_out + N_IN'(1);
                  state     <= S_SETTLE;
               end
            end
            S_DONE: begin
               bus.done <= 1'b0;
               bus.busy <= 1'b0;
               state    <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: a 2-input/SETTLE=1 instance exercised from a
// vector table plus corner sequences (abort by reset, ignored starts,
// back-to-back sweeps), and a 3-input/SETTLE=3 instance for long settle and
// all-mismatch counting. Per-minterm results go through a scoreboard queue.
module tb_truth_table_sweeper;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   truth_table_sweeper_if #(.N_IN(2)) bus_a ();
   truth_table_sweeper_if #(.N_IN(3)) bus_b ();

   truth_table_sweeper #(.N_IN(2), .SETTLE(1), .EXPECT(4'b0010)) u_dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_a)
   );

   truth_table_sweeper #(.N_IN(3), .SETTLE(3), .EXPECT(8'h00)) u_dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_b)
   );

   // Implementation models: mode 0 both correct a'.b, 1 s_b = a.b',
   // 2 both wrongly a.b, 3 s_b = complement of s_a. Returns {s_a, s_b}.
   int   mode_a = 0;
   logic mode_b = 1'b0;

   function automatic logic [1:0] model_a(input int mode, input logic [1:0] x);
      logic a, b, f;
      a = x[1];
      b = x[0];
      f = ~a & b;
      case (mode)
         0:       return {f, f};
         1:       return {f, a & ~b};
         2:       return {a & b, a & b};
         default: return {f, ~f};
      endcase
   endfunction

   assign {bus_a.s_a, bus_a.s_b} = model_a(mode_a, bus_a.x_out);
   assign bus_b.s_a = 1'b0;
   assign bus_b.s_b = mode_b;

   function automatic logic exp_mis(input int mode, input logic [1:0] m);
      logic [1:0] o;
      logic [3:0] ev;
      logic       mis;
      o   = model_a(mode, m);
      ev  = 4'b0010;
      mis = (o[1] != o[0]);
`ifdef TT_EXPECT_EN
      mis = mis | (o[1] != ev[m]);
`endif
      return mis;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Scoreboard: one entry per minterm, pushed when a sweep is started.
   typedef struct {
      logic [1:0] x;
      logic       mis;
   } exp_t;

   exp_t sb[$];
   int   done_seen = 0;
   int   exp_dones = 0;
   bit   in_sweep = 0;
   logic [1:0] cur_x = '0;
   int   hold = 0;

   task automatic push_sweep(input int mode);
      exp_t e;
      for (int m = 0; m < 4; m++) begin
         e.x   = 2'(m);
         e.mis = exp_mis(mode, 2'(m));
         sb.push_back(e);
      end
   endtask

   // Monitor: a minterm's result is visible once x_out advances (or done rises).
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         in_sweep = 0;
      end else begin
         if (bus_a.done) done_seen++;
         if (bus_a.busy) begin
            if (!in_sweep) begin
               in_sweep = 1;
               cur_x    = bus_a.x_out;
               hold     = 1;
            end else if ((bus_a.x_out != cur_x) || bus_a.done) begin
               if (sb.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL sb_underflow: result for minterm %0d with no expectation", cur_x);
               end else begin
                  e = sb.pop_front();
                  chk("sb_x", cur_x, e.x);
                  chk("sb_mismatch", bus_a.mismatch, e.mis);
                  chk("sb_hold", hold, 2);
               end
               cur_x = bus_a.x_out;
               hold  = 1;
               if (bus_a.done) in_sweep = 0;
            end else begin
               hold++;
            end
         end
      end
   end

   // One sweep on instance A; bp = cycle to pulse start while busy (0 = none),
   // dp = also raise start in the done cycle. Returns the done cycle (-1 = timeout).
   task automatic run_sweep_a(input int mode, input int bp, input bit dp, output int done_cyc);
      mode_a = mode;
      push_sweep(mode);
      exp_dones++;
      @(negedge clk);
      bus_a.start = 1'b1;
      @(posedge clk);
      #1 bus_a.start = 1'b0;
      done_cyc = -1;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         bus_a.start = (c == bp);
         if (bus_a.done) begin
            done_cyc    = c;
            bus_a.start = dp;
            break;
         end
      end
      @(negedge clk);
      bus_a.start = 1'b0;
   endtask

   // One sweep on instance B, checking x_out holds 4 cycles and steps by one.
   task automatic run_sweep_b(input logic mode, output int done_cyc);
      logic [2:0] px;
      int         h;
      bit         seen;
      mode_b = mode;
      seen   = 0;
      h      = 0;
      px     = '0;
      @(negedge clk);
      bus_b.start = 1'b1;
      @(posedge clk);
      #1 bus_b.start = 1'b0;
      done_cyc = -1;
      for (int c = 1; c <= 80; c++) begin
         @(negedge clk);
         if (bus_b.busy) begin
            if (!seen) begin
               seen = 1;
               px   = bus_b.x_out;
               h    = 1;
               chk("b_first_x", bus_b.x_out, 0);
            end else if ((bus_b.x_out != px) || bus_b.done) begin
               chk("b_hold", h, 4);
               if (!bus_b.done) chk("b_step", bus_b.x_out, 3'(px + 3'd1));
               px = bus_b.x_out;
               h  = 1;
            end else begin
               h++;
            end
         end
         if (bus_b.done) begin
            done_cyc = c;
            break;
         end
      end
      @(negedge clk);
   endtask

   typedef struct {
      int mode;
      int exp_cnt;
      int exp_first;
   } vec_t;

   initial begin
      vec_t tbl[4];
      int   dc;
      int   d1;
      int   d2;

      tbl[0] = '{mode: 0, exp_cnt: 0, exp_first: 0};
      tbl[1] = '{mode: 1, exp_cnt: 2, exp_first: 1};
`ifdef TT_EXPECT_EN
      tbl[2] = '{mode: 2, exp_cnt: 2, exp_first: 1};
`else
      tbl[2] = '{mode: 2, exp_cnt: 0, exp_first: 0};
`endif
      tbl[3] = '{mode: 3, exp_cnt: 4, exp_first: 0};

      bus_a.start = 1'b0;
      bus_b.start = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_x_out", bus_a.x_out, 0);
      chk("rst_busy", bus_a.busy, 0);
      chk("rst_done", bus_a.done, 0);
      chk("rst_mismatch", bus_a.mismatch, 0);
      chk("rst_err_count", bus_a.err_count, 0);
      chk("rst_first_err", bus_a.first_err, 0);
      #2 rst_n = 1'b1;

      // Table-driven sweeps
      foreach (tbl[i]) begin
         run_sweep_a(tbl[i].mode, 0, 1'b0, dc);
         chk("tbl_done_cycle", dc, 9);
         chk("tbl_err_count", bus_a.err_count, tbl[i].exp_cnt);
         chk("tbl_first_err", bus_a.first_err, tbl[i].exp_first);
         chk("tbl_last_mismatch", bus_a.mismatch, exp_mis(tbl[i].mode, 2'd3));
         chk("tbl_busy_after", bus_a.busy, 0);
         chk("tbl_done_after", bus_a.done, 0);
      end

      // Abort by reset during the settle window of minterm 2
      mode_a = 0;
      push_sweep(0);
      @(negedge clk);
      bus_a.start = 1'b1;
      @(posedge clk);
      #1 bus_a.start = 1'b0;
      for (int c = 0; c < 20 && bus_a.x_out != 2'd2; c++) @(negedge clk);
      chk("abort_reach_m2", bus_a.x_out, 2);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_x_out", bus_a.x_out, 0);
      chk("abort_busy", bus_a.busy, 0);
      chk("abort_done", bus_a.done, 0);
      chk("abort_mismatch", bus_a.mismatch, 0);
      chk("abort_err_count", bus_a.err_count, 0);
      chk("abort_first_err", bus_a.first_err, 0);
      sb.delete();
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("abort_no_done", bus_a.done, 0);
      chk("abort_idle", bus_a.busy, 0);
      run_sweep_a(1, 0, 1'b0, dc);
      chk("post_abort_done_cycle", dc, 9);
      chk("post_abort_err_count", bus_a.err_count, 2);
      chk("post_abort_first_err", bus_a.first_err, 1);

      // Starts while busy and in the done cycle are ignored
      run_sweep_a(0, 4, 1'b1, dc);
      chk("ign_done_cycle", dc, 9);
      chk("ign_busy_after", bus_a.busy, 0);
      repeat (3) @(negedge clk);
      chk("ign_still_idle", bus_a.busy, 0);
      chk("ign_done_count", done_seen, exp_dones);

      // Held start: back-to-back sweeps with one idle cycle between
      mode_a = 0;
      push_sweep(0);
      push_sweep(0);
      exp_dones += 2;
      d1 = -1;
      d2 = -1;
      @(negedge clk);
      bus_a.start = 1'b1;
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         if (c == 10) chk("b2b_gap_busy", bus_a.busy, 0);
         if (bus_a.done) begin
            if (d1 < 0) begin
               d1 = c;
            end else begin
               d2 = c;
               bus_a.start = 1'b0;
               break;
            end
         end
      end
      bus_a.start = 1'b0;
      chk("b2b_first_done", d1, 9);
      chk("b2b_second_done", d2, 19);
      repeat (2) @(negedge clk);
      chk("b2b_no_third", bus_a.busy, 0);
      chk("b2b_done_count", done_seen, exp_dones);
      chk("sb_drained", sb.size(), 0);

      // Wide instance: SETTLE=3, N_IN=3
      run_sweep_b(1'b1, dc);
      chk("b_done_cycle", dc, 33);
      chk("b_err_count_all", bus_b.err_count, 8);
      chk("b_first_err", bus_b.first_err, 0);
      chk("b_mismatch_last", bus_b.mismatch, 1);
      run_sweep_b(1'b0, dc);
      chk("b_done_cycle_clean", dc, 33);
      chk("b_err_count_clean", bus_b.err_count, 0);
      chk("b_busy_after", bus_b.busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
